// File: rtl/prog_load_ctrl_if.sv
// Byte-stream input and loader write port of the program loader, grouped as one bundle.
// The slave modport is the controller's view; master is the surrounding system's view.
interface prog_load_ctrl_if #(
    parameter int ADDR_LEN = 32
);
    logic                in_valid;
    logic [7:0]          in_data;
    logic                in_ready;
    logic [ADDR_LEN-1:0] addr;
    logic [127:0]        data;
    logic                we_32;
    logic                we_128;
    logic                loading;
    logic                done;
    logic                err;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output addr,
        output data,
        output we_32,
        output we_128,
        output loading,
        output done,
        output err
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  addr,
        input  data,
        input  we_32,
        input  we_128,
        input  loading,
        input  done,
        input  err
    );
endinterface

// File: rtl/prog_load_ctrl.sv
// Post-reset program loader: reads a word-count header and that many little-endian words,
// writing each word to dmem and every completed (or zero-padded) 4-word line to imem.
module prog_load_ctrl #(
    parameter int ADDR_LEN  = 32,
    parameter int MAX_WORDS = 2048,
    parameter int CNT_W     = 12
) (
    input  logic            clk,
    input  logic            reset_x,
    prog_load_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_HDR,
        ST_DATA,
        ST_FLUSH,
        ST_FIN,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         asm_q, asm_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [127:0]        data_q, data_d;
    logic [ADDR_LEN-1:0] addr_q, addr_d;
    logic                we32_q, we32_d;
    logic                we128_q, we128_d;
    logic [1:0]          flush_cnt_q, flush_cnt_d;

    logic                in_ready;
    logic                collecting;
    logic                byte_fire;
    logic                word_fire;
    logic [31:0]         word_full;
    logic [CNT_W-1:0]    word_cnt_inc;
    logic [CNT_W-1:0]    last_word;

    // ERR keeps draining bytes so the upstream receiver never backs up.
    assign in_ready     = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_ERR);
    assign collecting   = (state_q == ST_HDR) || (state_q == ST_DATA);
    assign byte_fire    = bus.in_valid && in_ready;
    assign word_fire    = byte_fire && collecting && (byte_idx_q == 2'd3);
    assign word_full    = {bus.in_data, asm_q};
    assign word_cnt_inc = word_cnt_q + CNT_W'(1);
    assign last_word    = word_cnt_q - CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        n_d         = n_q;
        word_cnt_d  = word_cnt_q;
        data_d      = data_q;
        addr_d      = addr_q;
        flush_cnt_d = flush_cnt_q;
        we32_d      = 1'b0;
        we128_d     = 1'b0;

        if (byte_fire && collecting) begin
            byte_idx_d = byte_idx_q + 2'd1;
            case (byte_idx_q)
                2'd0:    asm_d[7:0]   = bus.in_data;
                2'd1:    asm_d[15:8]  = bus.in_data;
                2'd2:    asm_d[23:16] = bus.in_data;
                default: asm_d        = asm_q;
            endcase
        end

        case (state_q)
            ST_HDR: begin
                if (word_fire) begin
                    if (word_full == 32'd0) begin
                        state_d = ST_DONE;
                    end else if (word_full > 32'(MAX_WORDS)) begin
                        state_d = ST_ERR;
                    end else begin
                        n_d     = word_full[CNT_W-1:0];
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (word_fire) begin
                    we32_d     = 1'b1;
                    we128_d    = (word_cnt_q[1:0] == 2'b11);
                    addr_d     = ADDR_LEN'({word_cnt_q, 2'b00});
                    data_d     = {word_full, data_q[127:32]};
                    word_cnt_d = word_cnt_inc;
                    if (word_cnt_inc == n_q) begin
                        if (n_q[1:0] == 2'b00) begin
                            state_d = ST_FIN;
                        end else begin
                            // Words still missing from the final line: 4 - N%4, modulo 4.
                            flush_cnt_d = 2'd0 - n_q[1:0];
                            state_d     = ST_FLUSH;
                        end
                    end
                end
            end

            ST_FLUSH: begin
                data_d      = {32'd0, data_q[127:32]};
                flush_cnt_d = flush_cnt_q - 2'd1;
                if (flush_cnt_q == 2'd1) begin
                    we128_d = 1'b1;
                    addr_d  = ADDR_LEN'({last_word[CNT_W-1:2], 4'b0000});
                    state_d = ST_FIN;
                end
            end

            // One cycle so DONE starts strictly after the final line write.
            ST_FIN:  state_d = ST_DONE;
            ST_DONE: state_d = ST_DONE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge reset_x) begin
        if (!reset_x) begin
            state_q     <= ST_HDR;
            byte_idx_q  <= 2'd0;
            asm_q       <= 24'd0;
            n_q         <= '0;
            word_cnt_q  <= '0;
            data_q      <= 128'd0;
            addr_q      <= '0;
            we32_q      <= 1'b0;
            we128_q     <= 1'b0;
            flush_cnt_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            n_q         <= n_d;
            word_cnt_q  <= word_cnt_d;
            data_q      <= data_d;
            addr_q      <= addr_d;
            we32_q      <= we32_d;
            we128_q     <= we128_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.in_ready = in_ready;
    assign bus.addr     = addr_q;
    assign bus.data     = data_q;
    assign bus.we_32    = we32_q;
    assign bus.we_128   = we128_q;
    assign bus.loading  = (state_q != ST_DONE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.err      = (state_q == ST_ERR);

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: logs every write strobe and compares the logged
// sequence, timing and status flags against hand-computed expectations per scenario.
module tb_prog_load_ctrl;

    logic clk = 1'b0;
    logic reset_x = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    prog_load_ctrl_if #(.ADDR_LEN(32)) bus();

    prog_load_ctrl #(
        .ADDR_LEN (32),
        .MAX_WORDS(2048),
        .CNT_W    (12)
    ) dut (
        .clk    (clk),
        .reset_x(reset_x),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]  wr32_addr[$];
    logic [31:0]  wr32_word[$];
    int           wr32_cyc[$];
    logic [31:0]  wr128_addr[$];
    logic [127:0] wr128_data[$];
    int           wr128_cyc[$];
    int           done_cyc = -1;

    always @(negedge clk) begin
        if (bus.we_32 === 1'b1) begin
            wr32_addr.push_back(bus.addr);
            wr32_word.push_back(bus.data[127:96]);
            wr32_cyc.push_back(cyc);
            $display("[%0d] we_32  addr=%h word=%h", cyc, bus.addr, bus.data[127:96]);
        end
        if (bus.we_128 === 1'b1) begin
            wr128_addr.push_back(bus.addr);
            wr128_data.push_back(bus.data);
            wr128_cyc.push_back(cyc);
            $display("[%0d] we_128 addr=%h line=%h", cyc, bus.addr, bus.data);
        end
        if (bus.done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    end

    task automatic clear_log();
        wr32_addr.delete();  wr32_word.delete();  wr32_cyc.delete();
        wr128_addr.delete(); wr128_data.delete(); wr128_cyc.delete();
        done_cyc = -1;
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset_x = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_x = 1'b1;
        clear_log();
    endtask

    // Presents one byte and returns 1 time unit after the edge that transferred it.
    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) begin
            checks++; failures++;
            $display("FAIL send_byte.timeout in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int i = 0; i < 4; i++) begin
            int gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
            repeat (gap) begin @(posedge clk); #1; end
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.addr !== 32'd0 || bus.data !== 128'd0 ||
            bus.we_32 !== 1'b0 || bus.we_128 !== 1'b0 || bus.loading !== 1'b1 ||
            bus.done !== 1'b0 || bus.err !== 1'b0)
        begin
            failures++;
            $display("FAIL reset.outputs got rdy=%b addr=%h data=%h we=%b%b ld=%b dn=%b er=%b required rdy=1 zeros ld=1",
                     bus.in_ready, bus.addr, bus.data, bus.we_32, bus.we_128, bus.loading, bus.done, bus.err);
        end
    endtask

    task automatic test_four_words();
        logic [31:0] w[4] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h00FFEEDD};
        do_reset();
        send_word(32'd4, 0);
        for (int i = 0; i < 4; i++) send_word(w[i], 0);
        repeat (4) @(negedge clk);
        checks++;
        if (wr32_addr.size() != 4 || wr128_addr.size() != 1) begin
            failures++;
            $display("FAIL four.counts got we32=%0d we128=%0d required 4/1", wr32_addr.size(), wr128_addr.size());
        end
        for (int i = 0; i < 4 && i < wr32_addr.size(); i++) begin
            checks++;
            if (wr32_addr[i] !== 32'(4 * i) || wr32_word[i] !== w[i]) begin
                failures++;
                $display("FAIL four.we32[%0d] got %h/%h required %h/%h", i, wr32_addr[i], wr32_word[i], 4 * i, w[i]);
            end
        end
        if (wr128_addr.size() == 1 && wr32_cyc.size() == 4) begin
            checks++;
            if (wr128_addr[0] !== 32'h0C || wr128_data[0] !== 128'h00FFEEDD_CCBBAA99_88776655_44332211 ||
                wr128_cyc[0] != wr32_cyc[3])
            begin
                failures++;
                $display("FAIL four.we128 got addr=%h line=%h cyc=%0d required 0c/00ffeedd_ccbbaa99_88776655_44332211 cyc=%0d",
                         wr128_addr[0], wr128_data[0], wr128_cyc[0], wr32_cyc[3]);
            end
            checks++;
            if (done_cyc != wr32_cyc[3] + 1 || bus.loading !== 1'b0) begin
                failures++;
                $display("FAIL four.done got done_cyc=%0d loading=%b required %0d/0", done_cyc, bus.loading, wr32_cyc[3] + 1);
            end
        end
    endtask

    task automatic test_partial_line();
        do_reset();
        send_word(32'd5, 0);
        for (int i = 0; i < 5; i++) send_word(32'hA0 + 32'(i), 0);
        // Now in the write cycle of the fifth word; the controller must not take bytes.
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL partial.in_ready cycle %0d got %b required 0", i, bus.in_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (wr32_addr.size() != 5 || wr128_addr.size() != 2) begin
            failures++;
            $display("FAIL partial.counts got we32=%0d we128=%0d required 5/2", wr32_addr.size(), wr128_addr.size());
        end else begin
            checks++;
            if (wr32_addr[4] !== 32'h10 || wr32_word[4] !== 32'hA4) begin
                failures++;
                $display("FAIL partial.we32_last got %h/%h required 10/a4", wr32_addr[4], wr32_word[4]);
            end
            checks++;
            if (wr128_addr[0] !== 32'h0C || wr128_data[0] !== {32'hA3, 32'hA2, 32'hA1, 32'hA0}) begin
                failures++;
                $display("FAIL partial.line0 got %h/%h required 0c/a3_a2_a1_a0", wr128_addr[0], wr128_data[0]);
            end
            checks++;
            if (wr128_addr[1][12:4] !== 9'd1 || wr128_data[1] !== 128'h000000A4 ||
                wr128_cyc[1] != wr32_cyc[4] + 3 || done_cyc != wr32_cyc[4] + 4)
            begin
                failures++;
                $display("FAIL partial.flush got addr=%h line=%h cyc=%0d done=%0d required line 1, 0_0_0_a4, cyc=%0d done=%0d",
                         wr128_addr[1], wr128_data[1], wr128_cyc[1], done_cyc, wr32_cyc[4] + 3, wr32_cyc[4] + 4);
            end
        end
    endtask

    task automatic test_empty();
        do_reset();
        send_word(32'd0, 0);
        checks++;
        if (bus.done !== 1'b1 || bus.loading !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL empty.done got done=%b loading=%b rdy=%b required 1/0/0", bus.done, bus.loading, bus.in_ready);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (wr32_addr.size() != 0 || wr128_addr.size() != 0) begin
            failures++;
            $display("FAIL empty.strobes got we32=%0d we128=%0d required 0/0", wr32_addr.size(), wr128_addr.size());
        end
    endtask

    task automatic test_oversize();
        do_reset();
        send_word(32'h00000800, 0);
        checks++;
        if (bus.err !== 1'b0 || bus.in_ready !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL max_words.accept got err=%b rdy=%b done=%b required 0/1/0", bus.err, bus.in_ready, bus.done);
        end
        do_reset();
        send_word(32'h00000801, 0);
        checks++;
        if (bus.err !== 1'b1 || bus.loading !== 1'b1) begin
            failures++;
            $display("FAIL oversize.err got err=%b loading=%b required 1/1", bus.err, bus.loading);
        end
        for (int i = 0; i < 100; i++) send_byte(8'(i));
        repeat (3) @(negedge clk);
        checks++;
        if (wr32_addr.size() != 0 || wr128_addr.size() != 0 || bus.err !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL oversize.drain got we32=%0d we128=%0d err=%b done=%b required 0/0/1/0",
                     wr32_addr.size(), wr128_addr.size(), bus.err, bus.done);
        end
    endtask

    task automatic test_gaps();
        logic [31:0] w[8];
        for (int i = 0; i < 8; i++) w[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        do_reset();
        send_word(32'd8, 7);
        for (int i = 0; i < 8; i++) send_word(w[i], 7);
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL gaps.in_ready cycle %0d got %b required 0", i, bus.in_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (wr32_addr.size() != 8 || wr128_addr.size() != 2 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL gaps.counts got we32=%0d we128=%0d done=%b required 8/2/1",
                     wr32_addr.size(), wr128_addr.size(), bus.done);
        end
        for (int i = 0; i < 8 && i < wr32_addr.size(); i++) begin
            checks++;
            if (wr32_addr[i] !== 32'(4 * i) || wr32_word[i] !== w[i]) begin
                failures++;
                $display("FAIL gaps.we32[%0d] got %h/%h required %h/%h", i, wr32_addr[i], wr32_word[i], 4 * i, w[i]);
            end
        end
        for (int l = 0; l < 2 && l < wr128_addr.size(); l++) begin
            checks++;
            if (wr128_addr[l] !== 32'(16 * l + 12) ||
                wr128_data[l] !== {w[4*l+3], w[4*l+2], w[4*l+1], w[4*l]})
            begin
                failures++;
                $display("FAIL gaps.line%0d got %h/%h required %h/%h", l, wr128_addr[l], wr128_data[l],
                         16 * l + 12, {w[4*l+3], w[4*l+2], w[4*l+1], w[4*l]});
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] w[4] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D};
        do_reset();
        send_word(32'd1, 0);
        send_word(32'h5A5A5A5A, 0);
        // Write cycle of the only word: the strobe must vanish as soon as reset asserts.
        reset_x = 1'b0;
        #1;
        checks++;
        if (bus.we_32 !== 1'b0 || bus.addr !== 32'd0 || bus.data !== 128'd0) begin
            failures++;
            $display("FAIL reset_async.strobe got we32=%b data=%h required 0/0", bus.we_32, bus.data);
        end
        do_reset();
        send_word(32'd8, 0);
        for (int i = 0; i < 3; i++) send_word(32'h7700_0000 + 32'(i), 0);
        send_byte(8'h11);
        send_byte(8'h22);
        reset_x = 1'b0;
        #1;
        checks++;
        if (bus.we_32 !== 1'b0 || bus.we_128 !== 1'b0 || bus.data !== 128'd0 || bus.addr !== 32'd0 ||
            bus.loading !== 1'b1 || bus.in_ready !== 1'b1)
        begin
            failures++;
            $display("FAIL reset_mid.outputs got we=%b%b data=%h addr=%h ld=%b rdy=%b required 00/0/0/1/1",
                     bus.we_32, bus.we_128, bus.data, bus.addr, bus.loading, bus.in_ready);
        end
        do_reset();
        send_word(32'd4, 0);
        for (int i = 0; i < 4; i++) send_word(w[i], 0);
        repeat (4) @(negedge clk);
        checks++;
        if (wr32_addr.size() != 4 || wr128_addr.size() != 1 || bus.done !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid.counts got we32=%0d we128=%0d done=%b required 4/1/1",
                     wr32_addr.size(), wr128_addr.size(), bus.done);
        end
        for (int i = 0; i < 4 && i < wr32_addr.size(); i++) begin
            checks++;
            if (wr32_addr[i] !== 32'(4 * i) || wr32_word[i] !== w[i]) begin
                failures++;
                $display("FAIL reset_mid.we32[%0d] got %h/%h required %h/%h", i, wr32_addr[i], wr32_word[i], 4 * i, w[i]);
            end
        end
        if (wr128_addr.size() == 1) begin
            checks++;
            if (wr128_addr[0] !== 32'h0C || wr128_data[0] !== {w[3], w[2], w[1], w[0]}) begin
                failures++;
                $display("FAIL reset_mid.line got %h/%h required 0c/%h", wr128_addr[0], wr128_data[0], {w[3], w[2], w[1], w[0]});
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        test_reset();
        test_four_words();
        test_partial_line();
        test_empty();
        test_oversize();
        test_gaps();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
